// File: rtl/ppu_vram_responder_if.sv
// PPU rendering memory port: request/response bundle between the background
// fetch FSM (master) and the VRAM responder (slave).
interface ppu_vram_responder_if;
  logic [17:0] ppu_mem_addr;
  logic        ppu_mem_read_request;
  logic        ppu_mem_wr_request;
  logic [7:0]  ppu_mem_dout;
  logic [7:0]  ppu_mem_din;

  modport master (
    output ppu_mem_addr,
    output ppu_mem_read_request,
    output ppu_mem_wr_request,
    output ppu_mem_dout,
    input  ppu_mem_din
  );

  modport slave (
    input  ppu_mem_addr,
    input  ppu_mem_read_request,
    input  ppu_mem_wr_request,
    input  ppu_mem_dout,
    output ppu_mem_din
  );
endinterface

// File: rtl/ppu_vram_responder.sv
// Memory-side responder for the PPU rendering port. Decodes requests into CHR
// (external, fixed latency), mirrored nametable CIRAM and 32 x 6 palette RAM.
// Reads return data within two clocks of the request edge; slower CHR reads
// raise a sticky timing_violation.
// Optional build macro PPU_FOUR_SCREEN_EN: CIRAM doubles to 4 KB and
// mirror_mode 11 selects four-screen instead of single-screen upper.
module ppu_vram_responder #(
  parameter int unsigned CHR_LATENCY = 1,
  parameter int unsigned CIRAM_AW    = 11
) (
  input  logic                clk,
  input  logic                rst,
  ppu_vram_responder_if.slave ppu,
  input  logic [1:0]          mirror_mode,
  output logic [12:0]         chr_addr,
  output logic                chr_rd,
  output logic                chr_wr,
  output logic [7:0]          chr_wdata,
  input  logic [7:0]          chr_data,
  output logic                busy,
  output logic                timing_violation
);

`ifdef PPU_FOUR_SCREEN_EN
  localparam int unsigned RamAw = CIRAM_AW + 1;
`else
  localparam int unsigned RamAw = CIRAM_AW;
`endif
  localparam int unsigned RamDepth = 1 << RamAw;

  typedef enum logic [1:0] {RgChr, RgCiram, RgPal, RgNull} region_e;
  typedef enum logic [2:0] {
    StIdle, StRdCiram, StRdPal, StRdNull, StRdChr, StRdDone, StWr
  } state_e;

  // hi = addr[17:8]
  function automatic region_e decode(input logic [9:0] hi);
    if (hi[9:6] != 4'd0)      return RgNull;
    else if (!hi[5])          return RgChr;
    else if (hi[5:0] == 6'h3F) return RgPal;
    else                      return RgCiram;
  endfunction

  function automatic logic [RamAw-1:0] ciram_idx(input logic [11:0] a, input logic [1:0] mode);
    logic [1:0] page;
    case (mode)
      2'b00:   page = {1'b0, a[11]};
      2'b01:   page = {1'b0, a[10]};
      2'b10:   page = 2'b00;
`ifdef PPU_FOUR_SCREEN_EN
      default: page = a[11:10];
`else
      default: page = 2'b01;
`endif
    endcase
    return RamAw'({page, a[9:0]});
  endfunction

  // Sprite/background colour 0 entries at 0x10/14/18/1C alias the background ones
  function automatic logic [4:0] pal_idx(input logic [4:0] a);
    logic [4:0] i;
    i = a;
    if (i[4] && i[1:0] == 2'b00) i[4] = 1'b0;
    return i;
  endfunction

  logic [7:0]  ciram [RamDepth];
  logic [5:0]  pal   [32];

  state_e      state;
  region_e     rd_region;
  logic        rd_prev, wr_prev, wr_pending;
  logic [11:0] rd_addr;
  logic [17:0] w_addr;
  logic [7:0]  w_data, rdata, din_q;
  logic [1:0]  lat_cnt;
  logic [2:0]  cyc_cnt;

  logic        rd_edge, wr_edge, can_accept;
  logic [17:0] pend_addr;
  logic [7:0]  pend_data;

  assign rd_edge    = ppu.ppu_mem_read_request & ~rd_prev;
  assign wr_edge    = ppu.ppu_mem_wr_request & ~wr_prev;
  // New requests are taken in IDLE or at the edge that returns to IDLE
  assign can_accept = (state == StIdle) || (state == StWr) ||
                      ((state == StRdDone) && !wr_pending);
  // A write edge arriving while leaving RD_DONE replaces the pending write
  assign pend_addr  = wr_edge ? ppu.ppu_mem_addr : w_addr;
  assign pend_data  = wr_edge ? ppu.ppu_mem_dout : w_data;

  assign busy            = (state != StIdle);
  assign ppu.ppu_mem_din = din_q;

  // Internal RAM commit at the edge that leaves WR; contents survive reset
  always_ff @(posedge clk) begin
    if (state == StWr) begin
      if (decode(w_addr[17:8]) == RgCiram) ciram[ciram_idx(w_addr[11:0], mirror_mode)] <= w_data;
      if (decode(w_addr[17:8]) == RgPal)   pal[pal_idx(w_addr[4:0])] <= w_data[5:0];
    end
  end

  // Request FSM with registered strobes, read data and violation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= StIdle;
      rd_region        <= RgNull;
      rd_prev          <= 1'b0;
      wr_prev          <= 1'b0;
      wr_pending       <= 1'b0;
      rd_addr          <= '0;
      w_addr           <= '0;
      w_data           <= '0;
      rdata            <= '0;
      din_q            <= '0;
      lat_cnt          <= '0;
      cyc_cnt          <= '0;
      chr_addr         <= '0;
      chr_rd           <= 1'b0;
      chr_wr           <= 1'b0;
      chr_wdata        <= '0;
      timing_violation <= 1'b0;
    end else begin
      rd_prev <= ppu.ppu_mem_read_request;
      wr_prev <= ppu.ppu_mem_wr_request;
      chr_rd  <= 1'b0;
      chr_wr  <= 1'b0;
      // cyc_cnt = number of edges since E0, used to judge completion time
      if (state != StIdle) cyc_cnt <= cyc_cnt + 3'd1;

      case (state)
        StRdCiram: begin
          rdata <= ciram[ciram_idx(rd_addr, mirror_mode)];
          state <= StRdDone;
        end
        StRdPal: begin
          rdata <= {2'b00, pal[pal_idx(rd_addr[4:0])]};
          state <= StRdDone;
        end
        StRdNull: begin
          rdata <= 8'h00;
          state <= StRdDone;
        end
        StRdChr: begin
          if (lat_cnt == 2'(CHR_LATENCY - 1)) state <= StRdDone;
          else lat_cnt <= lat_cnt + 2'd1;
        end
        StRdDone: begin
          din_q <= (rd_region == RgChr) ? chr_data : rdata;
          if (cyc_cnt >= 3'd2) timing_violation <= 1'b1;
          state <= StIdle;
          if (wr_pending) begin
            wr_pending <= 1'b0;
            state      <= StWr;
            if (decode(pend_addr[17:8]) == RgChr) begin
              chr_wr    <= 1'b1;
              chr_addr  <= pend_addr[12:0];
              chr_wdata <= pend_data;
            end
          end
        end
        default: state <= StIdle;
      endcase

      if (can_accept && rd_edge) begin
        rd_addr   <= ppu.ppu_mem_addr[11:0];
        rd_region <= decode(ppu.ppu_mem_addr[17:8]);
        cyc_cnt   <= 3'd0;
        lat_cnt   <= 2'd0;
        case (decode(ppu.ppu_mem_addr[17:8]))
          RgChr: begin
            state    <= StRdChr;
            chr_rd   <= 1'b1;
            chr_addr <= ppu.ppu_mem_addr[12:0];
          end
          RgCiram: state <= StRdCiram;
          RgPal:   state <= StRdPal;
          default: state <= StRdNull;
        endcase
        if (wr_edge) begin
          wr_pending <= 1'b1;
          w_addr     <= ppu.ppu_mem_addr;
          w_data     <= ppu.ppu_mem_dout;
        end
      end else if (can_accept && wr_edge) begin
        state  <= StWr;
        w_addr <= ppu.ppu_mem_addr;
        w_data <= ppu.ppu_mem_dout;
        if (decode(ppu.ppu_mem_addr[17:8]) == RgChr) begin
          chr_wr    <= 1'b1;
          chr_addr  <= ppu.ppu_mem_addr[12:0];
          chr_wdata <= ppu.ppu_mem_dout;
        end
      end else if (wr_pending && wr_edge) begin
        w_addr <= ppu.ppu_mem_addr;
        w_data <= ppu.ppu_mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_ppu_vram_responder.sv
// Bench for ppu_vram_responder: two instances (CHR latency 1 and 2) share one
// stimulus stream and are compared against an address-map model of the
// memories kept here, plus a CHR memory model with per-instance latency.
module tb_ppu_vram_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] addr_s = '0;
  logic        rd_s = 1'b0, wr_s = 1'b0;
  logic [7:0]  dout_s = '0;
  logic [1:0]  mm = 2'b00;

  always #5 clk = ~clk;

  ppu_vram_responder_if bus1();
  ppu_vram_responder_if bus2();
  assign bus1.ppu_mem_addr = addr_s;
  assign bus1.ppu_mem_read_request = rd_s;
  assign bus1.ppu_mem_wr_request = wr_s;
  assign bus1.ppu_mem_dout = dout_s;
  assign bus2.ppu_mem_addr = addr_s;
  assign bus2.ppu_mem_read_request = rd_s;
  assign bus2.ppu_mem_wr_request = wr_s;
  assign bus2.ppu_mem_dout = dout_s;

  logic [12:0] chr_addr1, chr_addr2;
  logic        chr_rd1, chr_rd2, chr_wr1, chr_wr2, busy1, busy2, tv1, tv2;
  logic [7:0]  chr_wdata1, chr_wdata2, chr_data1, chr_data2;

  ppu_vram_responder #(.CHR_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .ppu(bus1), .mirror_mode(mm),
    .chr_addr(chr_addr1), .chr_rd(chr_rd1), .chr_wr(chr_wr1), .chr_wdata(chr_wdata1),
    .chr_data(chr_data1), .busy(busy1), .timing_violation(tv1)
  );
  ppu_vram_responder #(.CHR_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .ppu(bus2), .mirror_mode(mm),
    .chr_addr(chr_addr2), .chr_rd(chr_rd2), .chr_wr(chr_wr2), .chr_wdata(chr_wdata2),
    .chr_data(chr_data2), .busy(busy2), .timing_violation(tv2)
  );

  // CHR memory: data valid for exactly one cycle, L clocks after the strobe
  bit [7:0]   chr_mem [8192];
  int         chr_wr_cnt1 = 0, chr_wr_cnt2 = 0;
  logic [8:0] c1_s1 = '0, c2_s1 = '0, c2_s2 = '0;
  always @(posedge clk) begin
    c1_s1 <= chr_rd1 ? {1'b1, chr_mem[chr_addr1]} : 9'h0;
    c2_s1 <= chr_rd2 ? {1'b1, chr_mem[chr_addr2]} : 9'h0;
    c2_s2 <= c2_s1;
    if (chr_wr1) begin
      chr_mem[chr_addr1] <= chr_wdata1;
      chr_wr_cnt1 <= chr_wr_cnt1 + 1;
    end
    if (chr_wr2) chr_wr_cnt2 <= chr_wr_cnt2 + 1;
  end
  assign chr_data1 = c1_s1[8] ? c1_s1[7:0] : 8'hEE;
  assign chr_data2 = c2_s2[8] ? c2_s2[7:0] : 8'hEE;

  // Reference model of the address map
  bit [7:0] m_ciram [4096];
  bit [7:0] m_chr   [8192];
  bit [7:0] m_pal   [32];
  int       n_cmp = 0, n_bad = 0;
  logic [7:0] last_din = 8'h00;

  function automatic int m_ciram_index(int a, int mode);
    int page;
    case (mode)
      0: page = (a / 2048) % 2;
      1: page = (a / 1024) % 2;
      2: page = 0;
`ifdef PPU_FOUR_SCREEN_EN
      default: page = (a / 1024) % 4;
`else
      default: page = 1;
`endif
    endcase
    return page * 1024 + a % 1024;
  endfunction

  function automatic int m_pal_index(int a);
    int idx;
    idx = a % 32;
    if (idx >= 16 && idx % 4 == 0) idx = idx - 16;
    return idx;
  endfunction

  function automatic logic [7:0] model_read(int a);
    if (a >= 'h4000) return 8'h00;
    if (a < 'h2000) return m_chr[a];
    if (a >= 'h3F00) return m_pal[m_pal_index(a)] & 8'h3F;
    return m_ciram[m_ciram_index(a, int'(mm))];
  endfunction

  function automatic void model_write(int a, logic [7:0] d);
    if (a >= 'h4000) return;
    if (a < 'h2000) m_chr[a] = d;
    else if (a >= 'h3F00) m_pal[m_pal_index(a)] = d & 8'h3F;
    else m_ciram[m_ciram_index(a, int'(mm))] = d;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // One request; checks completion edge of u_dut1 and read data of both.
  task automatic run_op(input bit rd, input bit wr, input logic [17:0] addr,
                        input logic [7:0] data, input bit use_tab,
                        input logic [7:0] tab_exp, input string name);
    logic [7:0] exp;
    int n1, want;
    bit done;
    exp = use_tab ? tab_exp : model_read(int'(addr));
    @(negedge clk);
    addr_s = addr; dout_s = data; rd_s = rd; wr_s = wr;
    @(posedge clk); #1;
    check({name, " busy@E0"}, busy1, 1);
    @(negedge clk);
    rd_s = 1'b0; wr_s = 1'b0;
    if (wr) model_write(int'(addr), data);
    n1 = 0; done = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (n1 == 0 && !busy1) n1 = k;
      if (!busy1 && !busy2) begin
        done = 1;
        break;
      end
    end
    want = rd ? (wr ? 3 : 2) : 1;
    check({name, " done"}, done, 1);
    check({name, " idle edge"}, n1, want);
    if (rd) begin
      check({name, " din1"}, bus1.ppu_mem_din, exp);
      check({name, " din2"}, bus2.ppu_mem_din, exp);
      last_din = exp;
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    bit          wr;
    logic [17:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs [18];

  initial begin
    int cnt1, cnt2;
    logic [7:0] e, prev;

    vecs[0]  = '{2'b01, 1, 18'h02405, 8'h11, 8'h00, "v wr 2405"};
    vecs[1]  = '{2'b01, 1, 18'h02005, 8'h5A, 8'h00, "v wr 2005"};
    vecs[2]  = '{2'b01, 0, 18'h02805, 8'h00, 8'h5A, "v rd 2805"};
    vecs[3]  = '{2'b01, 0, 18'h02C05, 8'h00, 8'h11, "v rd 2C05"};
    vecs[4]  = '{2'b00, 1, 18'h02000, 8'hA5, 8'h00, "h wr 2000"};
    vecs[5]  = '{2'b00, 1, 18'h02800, 8'h3C, 8'h00, "h wr 2800"};
    vecs[6]  = '{2'b00, 0, 18'h02400, 8'h00, 8'hA5, "h rd 2400"};
    vecs[7]  = '{2'b00, 0, 18'h02C00, 8'h00, 8'h3C, "h rd 2C00"};
    vecs[8]  = '{2'b00, 1, 18'h03F10, 8'hFF, 8'h00, "pal wr 3F10"};
    vecs[9]  = '{2'b00, 0, 18'h03F00, 8'h00, 8'h3F, "pal rd 3F00"};
    vecs[10] = '{2'b00, 0, 18'h03F30, 8'h00, 8'h3F, "pal rd 3F30"};
    vecs[11] = '{2'b00, 1, 18'h03F15, 8'hEA, 8'h00, "pal wr 3F15"};
    vecs[12] = '{2'b00, 0, 18'h03F15, 8'h00, 8'h2A, "pal rd 3F15"};
    vecs[13] = '{2'b00, 1, 18'h12005, 8'h99, 8'h00, "null wr"};
    vecs[14] = '{2'b00, 0, 18'h02005, 8'h00, 8'h5A, "null wr dropped"};
    vecs[15] = '{2'b00, 0, 18'h10000, 8'h00, 8'h00, "null rd"};
    vecs[16] = '{2'b10, 0, 18'h02C05, 8'h00, 8'h5A, "single lower"};
    vecs[17] = '{2'b11, 0, 18'h02405, 8'h00, 8'h11, "mode 11 page1"};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst din", bus1.ppu_mem_din, 8'h00);
    check("rst chr_rd", chr_rd1, 0);
    check("rst chr_wr", chr_wr1, 0);
    check("rst chr_addr", chr_addr1, 13'h0);
    check("rst chr_wdata", chr_wdata1, 8'h00);
    check("rst busy", busy1, 0);
    check("rst tv", tv1, 0);

    // Pre-fill all CIRAM and palette so no read hits uninitialised storage
`ifdef PPU_FOUR_SCREEN_EN
    mm = 2'b11;
    for (int i = 0; i < 4096; i++)
      run_op(0, 1, 18'(32'h2000 + i), 8'($urandom), 0, 8'h00, "fill");
`else
    mm = 2'b10;
    for (int i = 0; i < 1024; i++)
      run_op(0, 1, 18'(32'h2000 + i), 8'($urandom), 0, 8'h00, "fill");
    mm = 2'b11;
    for (int i = 0; i < 1024; i++)
      run_op(0, 1, 18'(32'h2000 + i), 8'($urandom), 0, 8'h00, "fill");
`endif
    for (int i = 0; i < 32; i++)
      run_op(0, 1, 18'(32'h3F00 + i), 8'($urandom), 0, 8'h00, "fill pal");

    // Directed vectors
    for (int i = 0; i < 18; i++) begin
      mm = vecs[i].mode;
      run_op(!vecs[i].wr, vecs[i].wr, vecs[i].addr, vecs[i].data, 1, vecs[i].exp,
             vecs[i].name);
    end

    // CHR write then read, latency 1 and 2
    cnt1 = chr_wr_cnt1; cnt2 = chr_wr_cnt2;
    run_op(0, 1, 18'h00123, 8'h77, 0, 8'h00, "chr wr");
    check("chr_wr pulses dut1", chr_wr_cnt1 - cnt1, 1);
    check("chr_wr pulses dut2", chr_wr_cnt2 - cnt2, 1);
    prev = last_din;
    @(negedge clk); addr_s = 18'h00123; rd_s = 1'b1;
    @(posedge clk); #1;
    check("chr_rd E0", chr_rd1, 1);
    check("chr_addr E0", chr_addr1, 13'h123);
    check("chr_rd2 E0", chr_rd2, 1);
    @(negedge clk); rd_s = 1'b0;
    @(posedge clk); #1;
    check("chr_rd E1", chr_rd1, 0);
    check("chr din E1", bus1.ppu_mem_din, prev);
    @(posedge clk); #1;
    check("chr din E2", bus1.ppu_mem_din, 8'h77);
    check("chr tv E2", tv1, 0);
    check("chr busy E2", busy1, 0);
    check("chr L2 din E2", bus2.ppu_mem_din, prev);
    @(posedge clk); #1;
    check("chr L2 din E3", bus2.ppu_mem_din, 8'h77);
    check("chr L2 tv E3", tv2, 1);
    check("chr L2 busy E3", busy2, 0);
    last_din = 8'h77;

    // Simultaneous read and write: old data returned, write commits after
    mm = 2'b00;
    run_op(0, 1, 18'h02001, 8'h10, 0, 8'h00, "wr 2001");
    run_op(1, 1, 18'h02001, 8'h33, 1, 8'h10, "rd+wr 2001");
    run_op(1, 0, 18'h02001, 8'h00, 1, 8'h33, "rd 2001 after");

    // Second write edge while one is pending: last write wins
    e = model_read(32'h2002);
    @(negedge clk); addr_s = 18'h02002; dout_s = 8'h44; rd_s = 1'b1; wr_s = 1'b1;
    @(posedge clk);
    @(negedge clk); rd_s = 1'b0; wr_s = 1'b0;
    @(posedge clk);
    @(negedge clk); wr_s = 1'b1; dout_s = 8'h55;
    @(posedge clk); #1;
    check("lww din", bus1.ppu_mem_din, e);
    @(negedge clk); wr_s = 1'b0;
    @(posedge clk); #1;
    check("lww idle", busy1, 0);
    model_write(32'h2002, 8'h55);
    run_op(1, 0, 18'h02002, 8'h00, 1, 8'h55, "lww readback");

    // Read edge while RD_DONE holds a pending write is ignored
    e = model_read(32'h3F07);
    @(negedge clk); addr_s = 18'h03F07; dout_s = 8'h15; rd_s = 1'b1; wr_s = 1'b1;
    @(posedge clk);
    @(negedge clk); rd_s = 1'b0; wr_s = 1'b0;
    @(posedge clk);
    @(negedge clk); rd_s = 1'b1;
    @(posedge clk); #1;
    check("ign din E2", bus1.ppu_mem_din, e);
    check("ign busy E2", busy1, 1);
    @(posedge clk); #1;
    check("ign idle E3", busy1, 0);
    @(posedge clk); #1;
    check("ign still idle E4", busy1, 0);
    @(negedge clk); rd_s = 1'b0;
    model_write(32'h3F07, 8'h15);
    last_din = e;
    run_op(1, 0, 18'h03F07, 8'h00, 1, 8'h15, "ign readback");

    // Randomised traffic against the model
    for (int n = 0; n < 150; n++) begin
      logic [17:0] a;
      int op;
      mm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = 18'($urandom_range(0, 'h1FFF));
        1: a = 18'($urandom_range('h2000, 'h3EFF));
        2: a = 18'('h3F00 + $urandom_range(0, 255));
        default: a = 18'(($urandom_range(1, 15) << 14) | $urandom_range(0, 'h3FFF));
      endcase
      op = $urandom_range(0, 2);
      run_op(op != 1, op != 0, a, 8'($urandom), 0, 8'h00, "rand");
    end
    check("tv1 never set", tv1, 0);
    check("tv2 held", tv2, 1);

    // Asynchronous reset during RD_CHR
    run_op(0, 1, 18'h03F01, 8'h2B, 0, 8'h00, "wr 3F01");
    @(negedge clk); addr_s = 18'h00123; rd_s = 1'b1;
    @(posedge clk); #1;
    check("pre-rst chr_rd", chr_rd1, 1);
    rd_s = 1'b0;
    rst = 1'b1;
    #1;
    check("rst chr_rd", chr_rd1, 0);
    check("rst busy1", busy1, 0);
    check("rst busy2", busy2, 0);
    check("rst din1", bus1.ppu_mem_din, 8'h00);
    check("rst tv2", tv2, 0);
    @(negedge clk); rst = 1'b0;
    run_op(1, 0, 18'h03F01, 8'h00, 1, 8'h2B, "rd 3F01 after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ppu_vram_responder.md
Name: ppu_vram_responder

Overview:
- Memory-side responder for the PPU rendering memory port. It services the single-cycle read and write requests issued by the background fetch FSM on the 18-bit PPU address bus.
- Decodes the address into three targets: CHR space (external pattern memory, fixed-latency), nametable CIRAM (internal, mirrored) and palette RAM (internal, 32 x 6 bit).
- Returns read data on ppu_mem_din within the 2-clock budget the FSM's take-slot requires.

Parameters:
- CHR_LATENCY, 1: clocks from chr_rd high to chr_data valid. Legal range is 1..3.
- CIRAM_AW, 11: CIRAM address width, giving 2 KB (two pages of 1 KB).

Ports:
- clk  in  1  system clock (25 MHz)
- rst  in  1  asynchronous, active-high reset
- ppu_mem_addr  in  18  request address; bits [17:14] must be 0, otherwise unmapped
- ppu_mem_read_request  in  1  read request; the rising edge is accepted
- ppu_mem_wr_request  in  1  write request; the rising edge is accepted
- ppu_mem_dout  in  8  write data, sampled with the write edge
- ppu_mem_din  out  8  read data, held until the next read completes
- mirror_mode  in  2  00 horizontal, 01 vertical, 10 single-screen lower, 11 single-screen upper
- chr_addr  out  13  CHR address
- chr_rd  out  1  CHR read strobe, one cycle
- chr_wr  out  1  CHR write strobe, one cycle (CHR-RAM)
- chr_wdata  out  8  CHR write data
- chr_data  in  8  CHR read data
- busy  out  1  high whenever the state is not IDLE
- timing_violation  out  1  sticky; set when a read completes later than edge E2

Behaviour:
- Reset values:
  - ppu_mem_din=0, chr_rd=0, chr_wr=0, chr_addr=0, chr_wdata=0, busy=0, timing_violation=0.
  - State returns to IDLE, the pending-write flag clears, and the edge-detect registers clear.
  - RAM contents are not cleared.
- Edge detection: registered copies of both request lines are kept. A request is accepted only on a 0->1 transition, and only while in IDLE or at the same edge the FSM enters IDLE.
  - E0 is the edge at which the read edge is sampled.
- Address decode uses a[13:0] = ppu_mem_addr[13:0]:
  - 0x0000-0x1FFF: CHR.
  - 0x2000-0x3EFF: CIRAM. Address is {page, a[9:0]}, where page = a[11] (horizontal), a[10] (vertical), 0 (mode 10) or 1 (mode 11).
  - 0x3F00-0x3FFF: palette at index a[4:0]. If a[4]=1 and a[1:0]=00, a[4] is forced to 0. Reads return {2'b00, data[5:0]}; writes store ppu_mem_dout[5:0].
  - ppu_mem_addr[17:14] != 0: reads return 0x00 and writes are dropped.
- States:
  - IDLE: on a read edge, latch the address and region and go to RD_CIRAM, RD_PAL, RD_CHR or RD_NULL. Otherwise, on a write edge, latch address and data and go to WR.
  - RD_CIRAM: BRAM access cycle -> RD_DONE.
  - RD_PAL: register read -> RD_DONE.
  - RD_NULL: -> RD_DONE with data 0x00.
  - RD_CHR: chr_rd high for one cycle (the cycle after E0). A latency counter counts CHR_LATENCY, then chr_data is captured -> RD_DONE.
  - RD_DONE: ppu_mem_din is updated. For CIRAM, palette and null reads this happens at E2. For CHR it happens at E(1+CHR_LATENCY); if that edge is after E2, timing_violation is set and held until reset. If a write is pending, go to WR; otherwise go to IDLE.
  - WR: commit in one cycle to CIRAM, palette, or CHR (chr_wr=1, chr_addr and chr_wdata driven), then -> IDLE.
- Simultaneous read and write edges: the read is serviced first. The write is latched into a one-entry pending buffer and commits in the WR state immediately after RD_DONE.
- A second write edge while a write is already pending overwrites the pending buffer (last write wins).
- A request edge while busy and not at the IDLE-entry edge is ignored.
- A read of the address being written in the same cycle returns the old data.
- Reset mid-operation (asynchronous):
  - All strobes drop immediately and the state goes to IDLE.
  - An in-flight CHR response is discarded and any pending write is lost.

Optional Feature:
- Macro: PPU_FOUR_SCREEN_EN.
- Defined:
  - CIRAM is 4 KB and mirror_mode 11 means four-screen, with CIRAM address {a[11:10], a[9:0]}.
  - Single-screen upper is no longer available.
- Undefined: CIRAM is 2 KB and mode 11 is single-screen upper, as described above.

Test Plan:
1. Vertical mirroring: set mirror_mode=01, write 0x2405=0x11, write 0x2005=0x5A. Then read 0x2805 -> 0x5A at E2, and read 0x2C05 -> 0x11.
2. Horizontal mirroring: set mirror_mode=00, write 0x2000=0xA5, write 0x2800=0x3C. Then read 0x2400 -> 0xA5, and read 0x2C00 -> 0x3C.
3. Palette: write 0x3F10=0xFF. Then read 0x3F00 -> 0x3F, and read 0x3F30 -> 0x3F.
4. CHR read, CHR_LATENCY=1: read 0x0123 with the model returning 0x77 -> chr_addr=0x123, chr_rd high one cycle, din=0x77 at E2, timing_violation=0. With CHR_LATENCY=2 -> din at E3 and timing_violation=1, held until reset.
5. Simultaneous read and write edges: with 0x2001=0x10, issue read 0x2001 and write 0x2001=0x33 in the same cycle -> din=0x10. The write then commits, and a following read -> 0x33.
6. Reset during RD_CHR -> chr_rd=0, busy=0 and din=0x00 immediately. A next read of 0x3F01 returns the stored value at E2.
